// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - pixel enable and timing outputs of the VGA timing generator
interface vga_timing_if;
    logic        en;
    logic [10:0] p_x;
    logic [9:0]  p_y;
    logic        active;
    logic        blank_n;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        input  en,
        output p_x, p_y, active, blank_n, hsync, vsync,
               line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  p_x, p_y, active, blank_n, hsync, vsync,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster position counters with registered sync, blank and frame pulses
module vga_timing #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] r_px;
    logic [9:0]  r_py;
    logic        r_active;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_line_start;
    logic        r_frame_start;
    logic [15:0] r_frame_count;

    logic [10:0] w_nx;
    logic [9:0]  w_ny;
    logic        w_n_active;
    logic        w_n_hsync;
    logic        w_n_vsync;
    logic        w_n_line;
    logic        w_n_frame;

    // All outputs are decoded from the next position so they land on the same edge as p_x/p_y.
    always_comb begin
        w_nx = r_px + 11'd1;
        w_ny = r_py;
        if (r_px == H_LAST) begin
            w_nx = '0;
            w_ny = (r_py == V_LAST) ? '0 : r_py + 10'd1;
        end
        w_n_active = (w_nx < H_ACT) && (w_ny < V_ACT);
        w_n_hsync  = ((w_nx >= HS_BEG) && (w_nx <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        w_n_vsync  = ((w_ny >= VS_BEG) && (w_ny <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        w_n_line   = (w_nx == '0);
        w_n_frame  = (w_nx == '0) && (w_ny == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px          <= H_LAST;
            r_py          <= V_LAST;
            r_active      <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else if (bus.en) begin
            r_px          <= w_nx;
            r_py          <= w_ny;
            r_active      <= w_n_active;
            r_hsync       <= w_n_hsync;
            r_vsync       <= w_n_vsync;
            r_line_start  <= w_n_line;
            r_frame_start <= w_n_frame;
            if (w_n_frame)
                r_frame_count <= r_frame_count + 16'd1;
        end else begin
            // Pulses are per advanced pixel, so a stalled pixel must not stretch them.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign bus.p_x         = r_px;
    assign bus.p_y         = r_py;
    assign bus.active      = r_active;
    assign bus.blank_n     = r_active;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed checks of vga_timing on a shortened 15x11 raster with active-low syncs
module tb_vga_timing;
    localparam int H_TOTAL = 15;
    localparam int V_TOTAL = 11;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    vga_timing_if bus ();

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        int          n;
        logic [10:0] x;
        logic [9:0]  y;
        logic        a;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input int n, input int x, input int y, input logic a,
                       input logic hs, input logic vs, input logic ls, input logic fs, input int fc);
        vec_t v;
        v.en = en; v.n = n; v.x = 11'(x); v.y = 10'(y); v.a = a;
        v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs; v.fc = 16'(fc);
        tbl.push_back(v);
    endtask

    function automatic logic [42:0] snap();
        return {bus.p_x, bus.p_y, bus.active, bus.blank_n, bus.hsync, bus.vsync,
                bus.line_start, bus.frame_start, bus.frame_count};
    endfunction

    function automatic logic [42:0] expv(input int x, input int y, input logic a, input logic hs,
                                         input logic vs, input logic ls, input logic fs, input int fc);
        return {11'(x), 10'(y), a, a, hs, vs, ls, fs, 16'(fc)};
    endfunction

    task automatic chk(input string name, input logic [42:0] act, input logic [42:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got x=%0d y=%0d act/bn/hs/vs/ls/fs=%b fc=%0d, expected x=%0d y=%0d act/bn/hs/vs/ls/fs=%b fc=%0d",
                     name, act[42:32], act[31:22], act[21:16], act[15:0],
                     exp[42:32], exp[31:22], exp[21:16], exp[15:0]);
        else
            n_pass++;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    int  cnt, n_act, n_hs, n_vs, n_ls, y0, ex, ey, bad, ls_seen;
    bit  found;

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        bus.en = 1'b0;

        // Reset values appear before any clock edge.
        #3;
        chk("reset_async", snap(), expv(14, 10, 0, 1, 1, 0, 0, 0));
        edge1();
        edge1();
        reset = 1'b0;
        chk("reset_hold", snap(), expv(14, 10, 0, 1, 1, 0, 0, 0));

        add(1, 1,  0,  0, 1, 1, 1, 1, 1, 1);
        add(0, 1,  0,  0, 1, 1, 1, 0, 0, 1);
        add(1, 1,  1,  0, 1, 1, 1, 0, 0, 1);
        add(1, 6,  7,  0, 1, 1, 1, 0, 0, 1);
        add(1, 1,  8,  0, 0, 1, 1, 0, 0, 1);
        add(1, 2, 10,  0, 0, 0, 1, 0, 0, 1);
        add(1, 2, 12,  0, 0, 0, 1, 0, 0, 1);
        add(1, 1, 13,  0, 0, 1, 1, 0, 0, 1);
        add(1, 1, 14,  0, 0, 1, 1, 0, 0, 1);
        add(1, 1,  0,  1, 1, 1, 1, 1, 0, 1);
        add(1, 67, 7,  5, 1, 1, 1, 0, 0, 1);
        add(1, 1,  8,  5, 0, 1, 1, 0, 0, 1);
        add(1, 7,  0,  6, 0, 1, 1, 1, 0, 1);
        add(1, 29, 14, 7, 0, 1, 1, 0, 0, 1);
        add(1, 1,  0,  8, 0, 1, 0, 1, 0, 1);
        add(1, 29, 14, 9, 0, 1, 0, 0, 0, 1);
        add(1, 1,  0, 10, 0, 1, 1, 1, 0, 1);
        add(1, 14, 14, 10, 0, 1, 1, 0, 0, 1);
        add(1, 1,  0,  0, 1, 1, 1, 1, 1, 2);

        foreach (tbl[i]) begin
            bus.en = tbl[i].en;
            for (int k = 0; k < tbl[i].n; k++) edge1();
            chk($sformatf("vec%0d", i), snap(),
                expv(tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs, tbl[i].fc));
        end

        // One full frame from frame_start to frame_start.
        bus.en = 1'b1;
        cnt = 0; n_act = 0; n_hs = 0; n_vs = 0; n_ls = 0; found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            edge1();
            cnt++;
            n_act += int'(bus.active);
            n_hs  += int'(bus.hsync == 1'b0);
            n_vs  += int'(bus.vsync == 1'b0);
            n_ls  += int'(bus.line_start);
            if (bus.frame_start) found = 1;
        end
        chk_int("frame_period", cnt, H_TOTAL * V_TOTAL);
        chk_int("frame_active", n_act, 48);
        chk_int("frame_hsync", n_hs, 3 * V_TOTAL);
        chk_int("frame_vsync", n_vs, 2 * H_TOTAL);
        chk_int("frame_lines", n_ls, V_TOTAL);
        chk_int("frame_count3", int'(bus.frame_count), 3);

        // en toggled 1,0,0,1 across a line wrap.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.p_x == 11'd14) found = 1;
            else edge1();
        end
        chk_int("reach_x14", int'(found), 1);
        y0 = (int'(bus.p_y) + 1) % V_TOTAL;
        ls_seen = 0;
        bus.en = 1'b1; edge1(); ls_seen += int'(bus.line_start);
        chk_int("tog_e1", int'(bus.p_x) * 1000 + int'(bus.p_y) * 10 + int'(bus.line_start), y0 * 10 + 1);
        bus.en = 1'b0; edge1(); ls_seen += int'(bus.line_start);
        chk_int("tog_e2", int'(bus.p_x) * 1000 + int'(bus.p_y) * 10 + int'(bus.line_start), y0 * 10);
        edge1(); ls_seen += int'(bus.line_start);
        chk_int("tog_e3", int'(bus.p_x) * 1000 + int'(bus.p_y) * 10 + int'(bus.line_start), y0 * 10);
        bus.en = 1'b1; edge1(); ls_seen += int'(bus.line_start);
        chk_int("tog_e4", int'(bus.p_x) * 1000 + int'(bus.p_y) * 10 + int'(bus.line_start), 1000 + y0 * 10);
        chk_int("tog_ls_count", ls_seen, 1);

        // Random stalls must neither skip nor repeat positions.
        ex = int'(bus.p_x); ey = int'(bus.p_y); bad = 0;
        for (int k = 0; k < 400; k++) begin
            bus.en = 1'($urandom_range(0, 1));
            if (bus.en) begin
                if (ex == H_TOTAL - 1) begin
                    ex = 0;
                    ey = (ey == V_TOTAL - 1) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end
            edge1();
            if (int'(bus.p_x) != ex || int'(bus.p_y) != ey) bad++;
        end
        chk_int("stall_positions_bad", bad, 0);

        // Reset in the middle of an hsync pulse clears everything at once.
        bus.en = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            edge1();
            if (bus.hsync == 1'b0) found = 1;
        end
        chk_int("reach_hsync", int'(found), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_midframe", snap(), expv(14, 10, 0, 1, 1, 0, 0, 0));
        edge1();
        chk("reset_midframe_hold", snap(), expv(14, 10, 0, 1, 1, 0, 0, 0));
        reset = 1'b0;
        edge1();
        chk("after_reset_first", snap(), expv(0, 0, 1, 1, 1, 1, 1, 1));

        // frame_count wraps from 65535 to 0.
        bus.en = 1'b0;
        edge1();
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        #1;
        chk_int("fc_preset", int'(bus.frame_count), 65535);
        bus.en = 1'b1;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            edge1();
            if (bus.frame_start) found = 1;
        end
        chk("fc_wrap", snap(), expv(0, 0, 1, 1, 1, 1, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
